// File: rtl/counter_driver_if.sv
// counter_driver_if: request/step/feedback bundle between control logic, counter_driver and the counter
interface counter_driver_if #(parameter int W = 3);
    logic         REQ;
    logic [W-1:0] TGT;
    logic [W-1:0] CO_FB;
    logic         UP;
    logic         DOWN;
    logic         BUSY;
    logic         DONE;
    logic         ERR;
    logic [3:0]   PULSES;
    modport master (input REQ, TGT, CO_FB, output UP, DOWN, BUSY, DONE, ERR, PULSES);
    modport slave  (output REQ, TGT, CO_FB, input UP, DOWN, BUSY, DONE, ERR, PULSES);
endinterface

// File: rtl/counter_driver.sv
// counter_driver: steps a saturating up/down counter to a requested value, confirming each step via CO feedback
module counter_driver #(
    parameter int W       = 3,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 8
) (
    input logic              CLK,
    input logic              MR,
    counter_driver_if.master bus
);
    typedef enum logic [1:0] {IDLE, COMPARE, PULSE, WAIT} state_t;
    state_t       state, nxt;
    logic [W-1:0] tgt, tgt_n, prev, prev_n;
    logic [3:0]   timer, timer_n, pulses_n;
    logic         dir, dir_n, up_n, down_n, busy_n, done_n, err_n;
    logic         step_ok;
    // widened compare so a wrap past either end never looks like a legal step
    assign step_ok = dir ? ({1'b0, bus.CO_FB} == {1'b0, prev} + 1'b1)
                         : ({1'b0, bus.CO_FB} == {1'b0, prev} - 1'b1);
    always_comb begin
        nxt      = state;
        tgt_n    = tgt;
        prev_n   = prev;
        timer_n  = timer;
        dir_n    = dir;
        pulses_n = bus.PULSES;
        busy_n   = bus.BUSY;
        up_n     = 1'b0;
        down_n   = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        unique case (state)
            IDLE: if (bus.REQ) begin
                nxt      = COMPARE;
                tgt_n    = bus.TGT;
                pulses_n = 4'd0;
                busy_n   = 1'b1;
            end
            COMPARE: if (bus.CO_FB == tgt) begin
                nxt    = IDLE;
                done_n = 1'b1;
                busy_n = 1'b0;
            end else begin
                nxt      = PULSE;
                dir_n    = bus.CO_FB < tgt;
                up_n     = dir_n;
                down_n   = !dir_n;
                timer_n  = 4'd0;
                pulses_n = bus.PULSES + 4'(bus.PULSES != 4'hF);
            end
            PULSE: begin
                nxt     = WAIT;
                prev_n  = bus.CO_FB;
                timer_n = timer + 4'd1;
            end
            WAIT: begin
                timer_n = timer + 4'd1;
                if (bus.CO_FB == prev) begin
                    if (timer == 4'(TIMEOUT - 1)) begin
                        nxt    = IDLE;
                        err_n  = 1'b1;
                        busy_n = 1'b0;
                    end
                end else if (!step_ok) begin
                    nxt    = IDLE;
                    err_n  = 1'b1;
                    busy_n = 1'b0;
                end else if (timer >= 4'(GAP)) begin
                    nxt = COMPARE;
                end
            end
        endcase
    end
    always_ff @(posedge CLK) begin
        if (MR) begin
            state      <= IDLE;
            tgt        <= '0;
            prev       <= '0;
            timer      <= '0;
            dir        <= 1'b0;
            bus.UP     <= 1'b0;
            bus.DOWN   <= 1'b0;
            bus.BUSY   <= 1'b0;
            bus.DONE   <= 1'b0;
            bus.ERR    <= 1'b0;
            bus.PULSES <= '0;
        end else begin
            state      <= nxt;
            tgt        <= tgt_n;
            prev       <= prev_n;
            timer      <= timer_n;
            dir        <= dir_n;
            bus.UP     <= up_n;
            bus.DOWN   <= down_n;
            bus.BUSY   <= busy_n;
            bus.DONE   <= done_n;
            bus.ERR    <= err_n;
            bus.PULSES <= pulses_n;
        end
    end
endmodule

// File: tb/tb_counter_driver.sv
// tb_counter_driver: directed stimulus against a lagging counter model, scoreboard-checked completions
module tb_counter_driver;
    localparam int W = 3, GAP = 2, TIMEOUT = 8;
    logic CLK = 1'b0;
    logic MR = 1'b1;
    always #5 CLK = ~CLK;
    counter_driver_if #(.W(W)) bus();
    counter_driver #(.W(W), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (.CLK(CLK), .MR(MR), .bus(bus));
    typedef struct {
        bit done;
        int endc;
        int pulses;
        int ups;
        int dns;
        int co;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0, cyc = 0;
    // counter model: 0 normal, 1 frozen, 2 steps opposite to UP; CO lags count by one register
    int mode = 0;
    logic ld = 1'b0;
    logic [2:0] ld_v = 3'd0, cnt = 3'd0, co = 3'd0;
    assign bus.CO_FB = co;
    function automatic logic [2:0] inc(input logic [2:0] v);
        return v == 3'd7 ? v : v + 3'd1;
    endfunction
    function automatic logic [2:0] dec(input logic [2:0] v);
        return v == 3'd0 ? v : v - 3'd1;
    endfunction
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (ld) begin
            cnt <= ld_v;
            co  <= ld_v;
        end else begin
            co <= cnt;
            if (mode != 1 && bus.UP) cnt <= mode == 2 ? dec(cnt) : inc(cnt);
            if (mode != 1 && bus.DOWN) cnt <= dec(cnt);
        end
    end
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    int ups = 0, dns = 0, last = 0;
    bit have_last = 0;
    always @(negedge CLK) begin
        exp_t e;
        if (MR) begin
            ups = 0;
            dns = 0;
            have_last = 0;
        end else begin
            if (bus.UP || bus.DOWN) begin
                chk("up_and_down", int'(bus.UP && bus.DOWN), 0);
                if (have_last) chk("pulse_spacing", cyc - last, 4);
                last = cyc;
                have_last = 1;
            end
            if (bus.UP) ups++;
            if (bus.DOWN) dns++;
            if (bus.DONE || bus.ERR) begin
                if (q.size() == 0) begin
                    chk("unexpected_end", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("done_vs_err", int'(bus.DONE), int'(e.done));
                    chk("end_cycle", cyc, e.endc);
                    chk("pulses", int'(bus.PULSES), e.pulses);
                    chk("up_count", ups, e.ups);
                    chk("down_count", dns, e.dns);
                    chk("co_at_end", int'(bus.CO_FB), e.co);
                    chk("busy_at_end", int'(bus.BUSY), 0);
                end
                ups = 0;
                dns = 0;
                have_last = 0;
            end
        end
    end
    task automatic wait_empty();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge CLK);
            n++;
        end
        if (q.size() != 0) begin
            chk("completion_timeout", q.size(), 0);
            q.delete();
        end
        @(negedge CLK);
    endtask
    task automatic load(input logic [2:0] v);
        @(negedge CLK);
        ld = 1'b1;
        ld_v = v;
        @(negedge CLK);
        ld = 1'b0;
        @(negedge CLK);
    endtask
    task automatic do_op(input logic [2:0] t, input bit d, input int lat, p, u, dn, c);
        @(negedge CLK);
        bus.REQ = 1'b1;
        bus.TGT = t;
        @(posedge CLK);
        #1;
        q.push_back('{d, cyc + lat, p, u, dn, c});
        bus.REQ = 1'b0;
        bus.TGT = ~t;
        wait_empty();
    endtask
    initial begin
        bus.REQ = 1'b0;
        bus.TGT = '0;
        ld = 1'b1;
        ld_v = 3'd0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_up", int'(bus.UP), 0);
        chk("rst_down", int'(bus.DOWN), 0);
        chk("rst_busy", int'(bus.BUSY), 0);
        chk("rst_done", int'(bus.DONE), 0);
        chk("rst_err", int'(bus.ERR), 0);
        chk("rst_pulses", int'(bus.PULSES), 0);
        MR = 1'b0;
        ld = 1'b0;
        do_op(3'd5, 1, 21, 5, 5, 0, 5);
        load(3'd6);
        do_op(3'd1, 1, 21, 5, 0, 5, 1);
        // already at target, REQ held so the second request lands in the DONE cycle
        load(3'd3);
        @(negedge CLK);
        bus.REQ = 1'b1;
        bus.TGT = 3'd3;
        @(posedge CLK);
        #1;
        q.push_back('{1, cyc + 1, 0, 0, 0, 3});
        @(posedge CLK);
        @(posedge CLK);
        #1;
        q.push_back('{1, cyc + 1, 0, 0, 0, 3});
        bus.REQ = 1'b0;
        wait_empty();
        mode = 1;
        load(3'd2);
        do_op(3'd4, 0, 9, 1, 1, 0, 2);
        mode = 2;
        load(3'd4);
        @(negedge CLK);
        bus.REQ = 1'b1;
        bus.TGT = 3'd6;
        @(posedge CLK);
        #1;
        q.push_back('{0, cyc + 4, 1, 1, 0, 3});
        bus.REQ = 1'b0;
        @(negedge CLK);
        bus.REQ = 1'b1;
        bus.TGT = 3'd0;
        @(negedge CLK);
        @(negedge CLK);
        bus.REQ = 1'b0;
        wait_empty();
        repeat (3) @(negedge CLK);
        chk("busy_after_err", int'(bus.BUSY), 0);
        chk("pulses_hold", int'(bus.PULSES), 1);
        mode = 0;
        load(3'd0);
        @(negedge CLK);
        bus.REQ = 1'b1;
        bus.TGT = 3'd7;
        @(posedge CLK);
        #1;
        bus.REQ = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        MR = 1'b1;
        @(negedge CLK);
        chk("mr_up", int'(bus.UP), 0);
        chk("mr_down", int'(bus.DOWN), 0);
        chk("mr_busy", int'(bus.BUSY), 0);
        chk("mr_done", int'(bus.DONE), 0);
        chk("mr_err", int'(bus.ERR), 0);
        chk("mr_pulses", int'(bus.PULSES), 0);
        @(negedge CLK);
        MR = 1'b0;
        repeat (4) @(negedge CLK);
        chk("idle_after_mr", int'(bus.BUSY), 0);
        do_op(3'd7, 1, 25, 6, 6, 0, 7);
        repeat (5) @(negedge CLK);
        chk("queue_left", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
